// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer and its jump-condition decoder.
// State encodings double as the debug value driven on the sequencer's state port.
package pc_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    // Instruction bit positions: C-instruction flag and the three jump bits.
    localparam int C_BIT = 15;
    localparam int J2    = 2;
    localparam int J1    = 1;
    localparam int J0    = 0;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Jump condition decoder: combines the three jump bits with the ALU zero/negative flags.
// Purely combinational so the CPU decode logic can share it.
module jump_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       cond
);

    logic pos;

    assign pos  = ~zr & ~ng;
    assign cond = (j[J2] & ng) | (j[J1] & zr) | (j[J0] & pos);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC load/inc/reset controls and the instruction fetch handshake.
// Optional self-jump halt detection is enabled by defining PC_SEQ_HALT_DETECT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] instr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] pc_out,
    input  logic [WIDTH-1:0] a_reg,
    input  logic             zr,
    input  logic             ng,
    output logic             imem_req,
    output logic [WIDTH-1:0] ir,
    output logic             exec_en,
    output logic [WIDTH-1:0] pc_in,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             pc_reset,
    output logic             halted,
    output logic [1:0]       state
);

    seq_state_t       state_reg;
    logic [WIDTH-1:0] ir_reg;
    logic             cond;
    logic             take;
    logic             self_jump;

    jump_cond u_jump_cond (
        .j    (ir_reg[J2:J0]),
        .zr   (zr),
        .ng   (ng),
        .cond (cond)
    );

    // A-instructions (C bit clear) never jump regardless of their low bits.
    assign take = ir_reg[C_BIT] & cond;

`ifdef PC_SEQ_HALT_DETECT_EN
    assign self_jump = take & (a_reg == pc_out);
    assign halted    = (state_reg == ST_HALT);
`else
    logic unused_pc_out;

    assign self_jump     = 1'b0;
    assign halted        = 1'b0;
    assign unused_pc_out = ^pc_out;
`endif

    // Reset is asynchronous so an in-flight fetch is abandoned without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_reg    <= instr;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_reg <= self_jump ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    if (!run) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Controls decode straight from state so the PC sees them in the same cycle.
    always_comb begin
        imem_req = 1'b0;
        exec_en  = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_reset = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pc_reset = 1'b1;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                pc_load = take & ~self_jump;
                pc_inc  = ~take;
            end
            default: begin
            end
        endcase
    end

    assign ir    = ir_reg;
    assign pc_in = a_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a cycle model.
// Build with PC_SEQ_HALT_DETECT_EN defined to exercise the halt-on-self-jump behaviour.
module tb_pc_sequencer;

`ifdef PC_SEQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] instr = '0;
    logic        imem_ack = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] a_reg = '0;
    logic        zr = 1'b0;
    logic        ng = 1'b0;
    logic        imem_req;
    logic [15:0] ir;
    logic        exec_en;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        pc_inc;
    logic        pc_reset;
    logic        halted;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 fetch, 2 exec, 3 halt; expected ir and expected PC value.
    int          m_st = 0;
    logic [15:0] m_ir = '0;
    logic [15:0] m_pc = '0;

    pc_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .instr    (instr),
        .imem_ack (imem_ack),
        .pc_out   (pc),
        .a_reg    (a_reg),
        .zr       (zr),
        .ng       (ng),
        .imem_req (imem_req),
        .ir       (ir),
        .exec_en  (exec_en),
        .pc_in    (pc_in),
        .pc_load  (pc_load),
        .pc_inc   (pc_inc),
        .pc_reset (pc_reset),
        .halted   (halted),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Program counter environment obeying the DUT's controls (wraps naturally at 16 bits).
    always @(posedge clk) begin
        if (pc_reset)     pc <= 16'h0000;
        else if (pc_load) pc <= pc_in;
        else if (pc_inc)  pc <= pc + 16'h0001;
    end

    function automatic logic m_take();
        logic pos;
        pos = ~zr & ~ng;
        return m_ir[15] & ((m_ir[2] & ng) | (m_ir[1] & zr) | (m_ir[0] & pos));
    endfunction

    function automatic logic m_self();
        return HALT_EN && (m_st == 2) && m_take() && (a_reg == m_pc);
    endfunction

    // Advance the model with the inputs present before the edge, then step one clock.
    task automatic cycle();
        case (m_st)
            0: begin
                m_pc = 16'h0000;
                if (run) m_st = 1;
            end
            1: if (imem_ack) begin
                m_ir = instr;
                m_st = 2;
            end
            2: begin
                if (m_self()) m_st = 3;
                else begin
                    if (m_take()) m_pc = a_reg;
                    else          m_pc = m_pc + 16'h0001;
                    m_st = 1;
                end
            end
            default: if (!run) m_st = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL rst_pc_reset got=%b exp=1", pc_reset); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL rst_ir got=%h exp=0000", ir); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        cycle();
        reset = 1'b0;
        run = 1'b1; imem_ack = 1'b1; instr = 16'h1234;
        #1;
        cycle();
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_req got=%b exp=1", imem_req); end
        cycle();
        imem_ack = 1'b0;
        cycle();
        #1;
        checks++; if (ir !== 16'h1234) begin errors++; $display("FAIL rst_ir_loaded got=%h exp=1234", ir); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_fetch_req got=%b exp=0", imem_req); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_mid_fetch_state got=%0d exp=0", state); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL rst_mid_fetch_ir got=%h exp=0000", ir); end
        checks++; if ({pc_load, pc_inc, pc_reset} !== 3'b001) begin errors++; $display("FAIL rst_mid_fetch_ctl got=%b exp=001", {pc_load, pc_inc, pc_reset}); end
        m_st = 0; m_ir = '0;
        run = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc_cleared got=%h exp=0000", pc); end
        $display("reset: async reset mid-fetch done");
    endtask

    task automatic test_straight_line();
        run = 1'b1; imem_ack = 1'b1; instr = 16'h0005;
        a_reg = 16'($urandom); zr = 1'($urandom); ng = 1'b0;
        #1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k % 2 == 0) begin
                checks++; if (state !== 2'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL line_fetch k=%0d got st=%0d req=%b exp st=1 req=1", k, state, imem_req); end
            end else begin
                checks++; if (state !== 2'd2 || exec_en !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0) begin
                    errors++; $display("FAIL line_exec k=%0d got st=%0d en=%b inc=%b ld=%b exp 2/1/1/0", k, state, exec_en, pc_inc, pc_load);
                end
                $display("line: exec ir=%h pc=%h", ir, pc);
            end
            checks++; if (pc !== 16'(k / 2)) begin errors++; $display("FAIL line_pc k=%0d got=%h exp=%h", k, pc, 16'(k / 2)); end
            cycle();
        end
        #1;
        checks++; if (pc !== 16'h0003 || state !== 2'd1) begin errors++; $display("FAIL line_end got pc=%h st=%0d exp pc=0003 st=1", pc, state); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b0; instr = 16'h7777;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (state !== 2'd1 || imem_req !== 1'b1 || ir !== 16'h0005) begin
                errors++; $display("FAIL stall_hold k=%0d got st=%0d req=%b ir=%h exp 1/1/0005", k, state, imem_req, ir);
            end
            checks++; if ({pc_load, pc_inc, pc_reset} !== 3'b000 || pc !== 16'h0003) begin
                errors++; $display("FAIL stall_ctl k=%0d got ctl=%b pc=%h exp 000/0003", k, {pc_load, pc_inc, pc_reset}, pc);
            end
            cycle();
        end
        instr = 16'h0042; imem_ack = 1'b1;
        cycle();
        #1;
        checks++; if (ir !== 16'h0042 || state !== 2'd2) begin errors++; $display("FAIL stall_ack got ir=%h st=%0d exp 0042/2", ir, state); end
        instr = 16'h7BEE;
        cycle();
        imem_ack = 1'b0;
        #1;
        checks++; if (ir !== 16'h0042 || pc !== 16'h0004) begin errors++; $display("FAIL stall_exec_ack got ir=%h pc=%h exp 0042/0004", ir, pc); end
        $display("stall: 3-cycle stall then ir=%h", ir);
    endtask

    task automatic test_jumps();
        logic [15:0] t_instr [6] = '{16'hE307, 16'hE301, 16'hE304, 16'hE302, 16'hE305, 16'h6307};
        logic [15:0] t_a     [6] = '{16'h00FF, 16'h1234, 16'h0ABC, 16'h2222, 16'h3333, 16'h5555};
        logic        t_zr    [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        t_ng    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        t_take  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] pc0;
        logic [15:0] pc_exp;
        for (int t = 0; t < 6; t++) begin
            instr = t_instr[t]; a_reg = t_a[t]; zr = t_zr[t]; ng = t_ng[t]; imem_ack = 1'b1;
            pc0 = pc;
            #1;
            cycle();
            #1;
            checks++; if (pc_load !== t_take[t] || pc_inc !== !t_take[t] || pc_in !== t_a[t]) begin
                errors++; $display("FAIL jump_ctl t=%0d got ld=%b inc=%b pc_in=%h exp ld=%b pc_in=%h", t, pc_load, pc_inc, pc_in, t_take[t], t_a[t]);
            end
            cycle();
            #1;
            pc_exp = t_take[t] ? t_a[t] : pc0 + 16'h0001;
            checks++; if (pc !== pc_exp) begin errors++; $display("FAIL jump_pc t=%0d got=%h exp=%h", t, pc, pc_exp); end
            $display("jump: ir=%h a=%h zr=%b ng=%b pc=%h", t_instr[t], t_a[t], t_zr[t], t_ng[t], pc);
        end
    endtask

    task automatic test_wrap();
        instr = 16'hE307; a_reg = 16'hFFFF; zr = 1'b0; ng = 1'b0; imem_ack = 1'b1;
        #1;
        cycle();
        cycle();
        instr = 16'h0007;
        #1;
        cycle();
        #1;
        checks++; if (pc !== 16'hFFFF || pc_inc !== 1'b1) begin errors++; $display("FAIL wrap_exec got pc=%h inc=%b exp FFFF/1", pc, pc_inc); end
        cycle();
        #1;
        checks++; if (pc !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc got pc=%h req=%b exp 0000/1", pc, imem_req); end
        $display("wrap: pc FFFF -> %h", pc);
    endtask

    task automatic test_halt();
        instr = 16'hE307; a_reg = 16'h0010; zr = 1'b0; ng = 1'b0; imem_ack = 1'b1; run = 1'b1;
        #1;
        cycle();
        cycle();
        #1;
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL halt_setup_pc got=%h exp=0010", pc); end
        instr = 16'hEA87;
        #1;
        cycle();
        #1;
`ifdef PC_SEQ_HALT_DETECT_EN
        checks++; if ({exec_en, pc_load, pc_inc} !== 3'b100) begin errors++; $display("FAIL halt_exec got en/ld/inc=%b exp=100", {exec_en, pc_load, pc_inc}); end
        cycle();
        #1;
        checks++; if (state !== 2'd3 || halted !== 1'b1 || pc !== 16'h0010) begin
            errors++; $display("FAIL halt_enter got st=%0d halted=%b pc=%h exp 3/1/0010", state, halted, pc);
        end
        cycle();
        #1;
        checks++; if (state !== 2'd3 || pc !== 16'h0010 || {pc_load, pc_inc, pc_reset, imem_req} !== 4'b0000) begin
            errors++; $display("FAIL halt_hold got st=%0d pc=%h ctl=%b exp 3/0010/0000", state, pc, {pc_load, pc_inc, pc_reset, imem_req});
        end
        run = 1'b0;
        cycle();
        #1;
        checks++; if (state !== 2'd0 || halted !== 1'b0) begin errors++; $display("FAIL halt_leave got st=%0d halted=%b exp 0/0", state, halted); end
        cycle();
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL halt_idle_pc got=%h exp=0000", pc); end
        $display("halt: self-jump halted at 0010, released to idle");
`else
        checks++; if (pc_load !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL selfjump_ctl got ld=%b halted=%b exp 1/0", pc_load, halted); end
        cycle();
        #1;
        checks++; if (state !== 2'd1 || pc !== 16'h0010 || halted !== 1'b0) begin
            errors++; $display("FAIL selfjump_loop got st=%0d pc=%h halted=%b exp 1/0010/0", state, pc, halted);
        end
        $display("halt: self-jump reloads pc=%h without halting", pc);
`endif
    endtask

    task automatic test_random();
        logic [5:0] e_ctl;
        logic       e_take;
        logic       e_self;
        for (int c = 0; c < 600; c++) begin
            run      = ($urandom_range(0, 3) != 0);
            imem_ack = ($urandom_range(0, 1) != 0);
            instr    = 16'($urandom);
            a_reg    = ($urandom_range(0, 3) == 0) ? m_pc : 16'($urandom);
            zr       = 1'($urandom);
            ng       = zr ? 1'b0 : 1'($urandom);
            #1;
            e_take = m_take();
            e_self = m_self();
            e_ctl  = {m_st == 1, m_st == 2, (m_st == 2) && e_take && !e_self,
                      (m_st == 2) && !e_take, m_st == 0, m_st == 3};
            checks++; if (state !== 2'(m_st) || ir !== m_ir) begin
                errors++; $display("FAIL rnd_state c=%0d got st=%0d ir=%h exp st=%0d ir=%h", c, state, ir, m_st, m_ir);
            end
            checks++; if ({imem_req, exec_en, pc_load, pc_inc, pc_reset, halted} !== e_ctl) begin
                errors++; $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, {imem_req, exec_en, pc_load, pc_inc, pc_reset, halted}, e_ctl);
            end
            checks++; if (pc !== m_pc || pc_in !== a_reg) begin
                errors++; $display("FAIL rnd_pc c=%0d got pc=%h pc_in=%h exp pc=%h pc_in=%h", c, pc, pc_in, m_pc, a_reg);
            end
            checks++; if ($countones({pc_load, pc_inc, pc_reset}) > 1) begin
                errors++; $display("FAIL rnd_onehot c=%0d got=%b exp at most one", c, {pc_load, pc_inc, pc_reset});
            end
            if (m_st == 2) $display("rnd: exec ir=%h pc=%h take=%b", m_ir, m_pc, e_take);
            cycle();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_jumps();
        test_wrap();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
